// File: rtl/audio_rec_pkg.sv
// Shared types and default sizes for the audio loop recorder.
// Holds the recorder state encoding and default sample/address widths.
package audio_rec_pkg;

   localparam int DEF_DATA_W = 24;
   localparam int DEF_ADDR_W = 14;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECORD = 2'd1,
      ST_PLAY   = 2'd2
   } rec_state_e;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample store: one write port, one synchronous read port.
// Read data appears one clock after rd_en_i and holds until the next read.
module sample_ram
   import audio_rec_pkg::*;
#(
   parameter int WIDTH  = 2 * DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o
);

   logic [WIDTH-1:0] mem_q [2**ADDR_W];
   logic [WIDTH-1:0] rd_data_q;

   // NOTE: neither the array nor its read register is reset, so this maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/audio_loop_recorder.sv
// Record/playback buffer for stereo codec samples with one-cycle live pass-through.
// Define LOOP_PLAYBACK_EN to repeat playback; otherwise playback ends after the last stored pair.
module audio_loop_recorder
   import audio_rec_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              CLOCK_50,
   input  logic              reset_n,
   input  logic              rec_req,
   input  logic              play_req,
   input  logic              stop_req,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_left,
   input  logic [DATA_W-1:0] in_right,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_left,
   output logic [DATA_W-1:0] out_right,
   output logic [1:0]        state,
   output logic [ADDR_W:0]   length
);

   localparam int              PAIR_W   = 2 * DATA_W;
   localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

   rec_state_e        state_q, state_d;
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   length_q, length_d;
   logic              out_valid_q;
   logic              sel_ram_q;
   logic [PAIR_W-1:0] live_q;
   logic [PAIR_W-1:0] ram_rdata;

   logic wr_en, rd_en, wr_last, rd_last;

   assign wr_en   = (state_q == ST_RECORD) && in_valid;
   assign rd_en   = (state_q == ST_PLAY) && in_valid;
   assign wr_last = wr_en && (wr_ptr_q == CAPACITY - ONE);
   assign rd_last = rd_en && (rd_ptr_q == length_q - ONE);

   sample_ram #(
      .WIDTH (PAIR_W),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk_i    (CLOCK_50),
      .wr_en_i  (wr_en),
      .wr_addr_i(wr_ptr_q[ADDR_W-1:0]),
      .wr_data_i({in_left, in_right}),
      .rd_en_i  (rd_en),
      .rd_addr_i(rd_ptr_q[ADDR_W-1:0]),
      .rd_data_o(ram_rdata)
   );

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned and no latch is inferred.
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      length_d = length_q;

      if (wr_en) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + ONE;

      if (stop_req) begin
         if (state_q == ST_RECORD) length_d = wr_ptr_d;
         state_d = ST_IDLE;
      end else if (rec_req) begin
         state_d  = ST_RECORD;
         wr_ptr_d = '0;
      end else if (play_req && (state_q == ST_IDLE) && (length_q != '0)) begin
         state_d  = ST_PLAY;
         rd_ptr_d = '0;
      end else if (wr_last) begin
         state_d  = ST_IDLE;
         length_d = CAPACITY;
      end else if (rd_last) begin
`ifdef LOOP_PLAYBACK_EN
         rd_ptr_d = '0;
`else
         state_d  = ST_IDLE;
`endif
      end
   end

   // NOTE: sequential state is updated with <= only; the combinational block above uses =.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         length_q    <= '0;
         out_valid_q <= 1'b0;
         sel_ram_q   <= 1'b0;
         live_q      <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         length_q    <= length_d;
         out_valid_q <= in_valid;
         // Output source is latched per strobe so samples hold between strobes.
         if (in_valid) begin
            sel_ram_q <= rd_en;
            live_q    <= {in_left, in_right};
         end
      end
   end

   assign {out_left, out_right} = sel_ram_q ? ram_rdata : live_q;
   assign out_valid = out_valid_q;
   assign state     = state_q;
   assign length    = length_q;

endmodule
